// File: rtl/dmi_pkg.sv
// Shared DMI definitions: register map, abstractcs fields,
// request op / response status encodings and initiator FSM states.
package dmi_pkg;

  localparam logic [6:0] DATA0      = 7'h04;
  localparam logic [6:0] DMCONTROL  = 7'h10;
  localparam logic [6:0] DMSTATUS   = 7'h11;
  localparam logic [6:0] ABSTRACTCS = 7'h16;
  localparam logic [6:0] COMMAND    = 7'h17;
  localparam logic [6:0] SBCS       = 7'h38;
  localparam logic [6:0] SBADDRESS0 = 7'h39;
  localparam logic [6:0] SBDATA0    = 7'h3C;

  localparam int ABSTRACTCS_BUSY = 12;
  localparam int CMDERR_LSB      = 8;
  localparam int CMDERR_MSB      = 10;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_POLL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BADOP   = 2'b01,
    ST_CMDERR  = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    POLL_RD,
    POLL_WAIT,
    RESP
  } state_t;

  function automatic status_t poll_status(input logic [31:0] cs);
    return (cs[CMDERR_MSB:CMDERR_LSB] != 3'd0) ? ST_CMDERR : ST_OK;
  endfunction

endpackage

// File: rtl/dmi_initiator.sv
// Host-side DMI master: one request in flight, read/write/write-then-poll.
// DMI_INIT_TIMEOUT_EN bounds each poll to POLL_MAX abstractcs reads.
module dmi_initiator
  import dmi_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int POLL_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic        dmi_wr,
  output logic        dmi_rd,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata
);

  localparam int PCW = $clog2(POLL_MAX + 1);

  state_t         state;
  op_t            op_q;
  logic [1:0]     lat_cnt;
  logic [PCW-1:0] poll_cnt;

  // Strobes are registered one-cycle pulses; every branch that wants
  // one sets it, otherwise the default below drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      lat_cnt    <= '0;
      poll_cnt   <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
      dmi_wr     <= 1'b0;
      dmi_rd     <= 1'b0;
      dmi_addr   <= '0;
      dmi_wdata  <= '0;
    end else begin
      dmi_wr <= 1'b0;
      dmi_rd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_q      <= op_t'(req_op);
            unique case (1'b1)
              (req_op == OP_NOP): begin
                state      <= RESP;
                rsp_valid  <= 1'b1;
                rsp_rdata  <= '0;
                rsp_status <= ST_BADOP;
              end
              (req_op == OP_READ): begin
                state    <= ISSUE;
                dmi_rd   <= 1'b1;
                dmi_addr <= req_addr;
              end
              default: begin
                state     <= ISSUE;
                dmi_wr    <= 1'b1;
                dmi_addr  <= req_addr;
                dmi_wdata <= req_wdata;
              end
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end

        ISSUE: begin
          unique case (op_q)
            OP_READ: begin
              state   <= WAIT_RD;
              lat_cnt <= 2'd1;
            end
            OP_POLL: begin
              state    <= POLL_RD;
              poll_cnt <= '0;
            end
            default: begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_rdata  <= '0;
              rsp_status <= ST_OK;
            end
          endcase
        end

        WAIT_RD: begin
          if (lat_cnt == 2'(RD_LAT)) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= dmi_rdata;
            rsp_status <= ST_OK;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        // Idle gap before each abstractcs read keeps strobes apart.
        POLL_RD: begin
          state    <= POLL_WAIT;
          dmi_rd   <= 1'b1;
          dmi_addr <= ABSTRACTCS;
          lat_cnt  <= '0;
        end

        POLL_WAIT: begin
          if (lat_cnt != 2'(RD_LAT)) begin
            lat_cnt <= lat_cnt + 2'd1;
          end else if (dmi_rdata[ABSTRACTCS_BUSY]) begin
`ifdef DMI_INIT_TIMEOUT_EN
            if (poll_cnt + 1'b1 == PCW'(POLL_MAX)) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_rdata  <= dmi_rdata;
              rsp_status <= ST_TIMEOUT;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              state    <= POLL_RD;
            end
`else
            if (poll_cnt != PCW'(POLL_MAX))
              poll_cnt <= poll_cnt + 1'b1;
            state <= POLL_RD;
`endif
          end else begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= dmi_rdata;
            rsp_status <= poll_status(dmi_rdata);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_initiator.sv
// Scoreboard bench for dmi_initiator with a DMI responder model
// (memory plus scripted abstractcs busy sequence).
module tb_dmi_initiator;

  localparam int RD_LAT = 1;
`ifdef DMI_INIT_TIMEOUT_EN
  localparam int POLL_MAX = 4;
`else
  localparam int POLL_MAX = 64;
`endif
  localparam time PER = 10;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        dmi_wr;
  logic        dmi_rd;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;

  dmi_initiator #(.RD_LAT(RD_LAT), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .dmi_wr(dmi_wr), .dmi_rd(dmi_rd),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
    .dmi_rdata(dmi_rdata)
  );

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  status;
    int          nwr;
    int          nrd;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] shadow[128];
  logic [31:0] mem[128];
  int          busy_left = 0;
  logic [31:0] cs_final = '0;
  int          rsp_mode = 0;
  time         hs_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_val(input int b);
    logic [31:0] v;
    v = 32'h0000_1000;
    v[23:16] = b[7:0];
    return v;
  endfunction

  function automatic logic [6:0] rand_addr();
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    if (a == 7'h16) a = 7'h04;
    return a;
  endfunction

  initial begin
    clk = 1'b0;
    forever #(PER / 2) clk = ~clk;
  end

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // DMI responder: rdata valid exactly RD_LAT cycles after the strobe.
  initial begin
    int lat;
    logic [31:0] val;
    logic rd_s, wr_s;
    logic [6:0] a;
    logic [31:0] d;
    lat = 0;
    val = '0;
    dmi_rdata = '0;
    forever begin
      @(posedge clk);
      rd_s = dmi_rd;
      wr_s = dmi_wr;
      a = dmi_addr;
      d = dmi_wdata;
      if (reset) begin
        lat = 0;
      end else begin
        if (wr_s) mem[a] = d;
        if (rd_s) begin
          lat = RD_LAT;
          if (a == 7'h16) begin
            if (busy_left > 0) begin
              val = busy_val(busy_left);
              busy_left--;
            end else begin
              val = cs_final;
            end
          end else begin
            val = mem[a];
          end
        end else if (lat > 0) begin
          lat--;
        end
      end
      #1;
      dmi_rdata = (lat == 1) ? val : $urandom;
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        1: rsp_ready = 1'b0;
        2: rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: strobe legality, response contents and strobe counts.
  initial begin
    int wr_n, rd_n;
    logic prev_strb;
    wr_n = 0;
    rd_n = 0;
    prev_strb = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_n = 0;
        rd_n = 0;
        prev_strb = 1'b0;
      end else begin
        if (dmi_wr || dmi_rd) begin
          chk("strobe_excl", 32'(dmi_wr & dmi_rd), 0);
          chk("strobe_gap", 32'(prev_strb), 0);
          if (sb.size() == 0) begin
            chk("strobe_unexpected", 32'(dmi_wr | dmi_rd), 0);
          end else if (dmi_wr) begin
            wr_n++;
            chk("wr_addr", 32'(dmi_addr), 32'(sb[0].addr));
            chk("wr_data", dmi_wdata, sb[0].wdata);
          end else begin
            rd_n++;
            chk("rd_addr", 32'(dmi_addr),
                (sb[0].op == 2'b11) ? 32'h16 : 32'(sb[0].addr));
          end
        end
        prev_strb = dmi_wr | dmi_rd;
        if (rsp_valid) begin
          chk("req_ready_busy", 32'(req_ready), 0);
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 0);
          end else begin
            chk("rsp_rdata", rsp_rdata, sb[0].rdata);
            chk("rsp_status", 32'(rsp_status), 32'(sb[0].status));
            if (rsp_ready) begin
              chk("rsp_nwr", wr_n, sb[0].nwr);
              chk("rsp_nrd", rd_n, sb[0].nrd);
              void'(sb.pop_front());
              wr_n = 0;
              rd_n = 0;
            end
          end
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [6:0] addr,
                        input logic [31:0] wd, input int nbusy,
                        input logic [31:0] fin);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout act=0 exp=1");
      return;
    end
    e.op = op;
    e.addr = addr;
    e.wdata = wd;
    e.rdata = '0;
    e.status = 2'b00;
    e.nwr = 0;
    e.nrd = 0;
    case (op)
      2'b00: e.status = 2'b01;
      2'b01: begin
        e.rdata = shadow[addr];
        e.nrd = 1;
      end
      2'b10: begin
        shadow[addr] = wd;
        e.nwr = 1;
      end
      default: begin
        shadow[addr] = wd;
        e.nwr = 1;
`ifdef DMI_INIT_TIMEOUT_EN
        if (nbusy >= POLL_MAX) begin
          e.nrd = POLL_MAX;
          e.rdata = busy_val(nbusy - POLL_MAX + 1);
          e.status = 2'b11;
        end else
`endif
        begin
          e.nrd = nbusy + 1;
          e.rdata = fin;
          e.status = (fin[10:8] != 3'd0) ? 2'b10 : 2'b00;
        end
      end
    endcase
    busy_left = nbusy;
    cs_final = fin;
    sb.push_back(e);
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk);
    hs_t = $time;
    #1;
    req_valid = 1'b0;
    req_op = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_status"}, 32'(rsp_status), 0);
    chk({tag, "_dmi_wr"}, 32'(dmi_wr), 0);
    chk({tag, "_dmi_rd"}, 32'(dmi_rd), 0);
    chk({tag, "_dmi_addr"}, 32'(dmi_addr), 0);
    chk({tag, "_dmi_wdata"}, dmi_wdata, 0);
  endtask

  initial begin
    time t0, t1, t2, t3;
    int n;
    logic [31:0] fin;
    for (int i = 0; i < 128; i++) begin
      mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      shadow[i] = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF;
    shadow[4] = 32'hDEAD_BEEF;
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(req_ready), 1);

    do_req(2'b10, 7'h10, 32'h8000_0001, 0, 0);
    do_req(2'b01, 7'h04, 0, 0, 0);
    do_req(2'b11, 7'h17, 32'h0022_1005, 3, 32'h0000_0000);
    do_req(2'b11, 7'h17, 32'h0022_1005, 2, 32'h0000_0200);
    do_req(2'b00, 7'h11, 32'h1234_5678, 0, 0);
`ifdef DMI_INIT_TIMEOUT_EN
    do_req(2'b11, 7'h17, 32'h0022_1005, 200, 0);
`endif
    drain();

    // Held response: must stay valid and stable, no new strobes.
    rsp_mode = 1;
    do_req(2'b01, 7'h10, 0, 0, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("hold_rsp_valid", 32'(rsp_valid), 1);
    chk("hold_req_ready", 32'(req_ready), 0);
    rsp_mode = 2;
    drain();

    do_req(2'b10, 7'h39, 32'h1111_2222, 0, 0);
    t0 = hs_t;
    do_req(2'b10, 7'h3C, 32'h3333_4444, 0, 0);
    t1 = hs_t;
    do_req(2'b01, 7'h3C, 0, 0, 0);
    t2 = hs_t;
    do_req(2'b01, 7'h39, 0, 0, 0);
    t3 = hs_t;
    chk("wr_throughput", 32'((t1 - t0) / PER), 3);
    chk("wr_rd_spacing", 32'((t2 - t1) / PER), 3);
    chk("rd_throughput", 32'((t3 - t2) / PER), 3 + RD_LAT);
    drain();
    rsp_mode = 0;

    for (int i = 0; i < 40; i++) begin
      fin = $urandom;
      fin[12] = 1'b0;
      do_req(2'($urandom_range(0, 3)), rand_addr(), $urandom,
             $urandom_range(0, 5), fin);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Reset while waiting on an abstractcs read.
    do_req(2'b11, 7'h17, 32'h0022_1005, 50, 0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (dmi_rd && dmi_addr == 7'h16) break;
      n++;
    end
    chk("poll_rd_seen", 32'(dmi_rd), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    busy_left = 0;
    @(posedge clk);
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_req_ready", 32'(req_ready), 1);
    chk("midreset_rsp_valid", 32'(rsp_valid), 0);

    do_req(2'b01, 7'h17, 0, 0, 0);
    do_req(2'b01, 7'h04, 0, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
